// File: rtl/calc_pkg.sv
// Shared definitions for the BCD operand converter: FSM states, default
// geometry and the minimum binary width needed for a given digit count.
package calc_pkg;

    localparam int unsigned DIGITS_DEF = 4;
    localparam int unsigned BIN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Bits to hold 10^digits - 1 as a magnitude, plus one sign bit.
    function automatic int unsigned min_bin_w(input int unsigned digits);
        longint unsigned maxv;
        int unsigned     bits;
        maxv = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            maxv = maxv * 64'd10;
        end
        maxv = maxv - 64'd1;
        bits = 0;
        while (maxv != 64'd0) begin
            bits++;
            maxv = maxv >> 1;
        end
        return bits + 1;
    endfunction

endpackage

// File: rtl/bcd_horner_step.sv
// One Horner step of BCD-to-binary conversion: acc*10 + digit, flagging a
// non-decimal nibble.
module bcd_horner_step
    import calc_pkg::*;
#(
    parameter int unsigned BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_out,
    output logic             digit_err
);

    always_comb begin
        acc_out   = (acc_in << 3) + (acc_in << 1) + {{(BIN_W-4){1'b0}}, digit};
        digit_err = (digit > 4'd9);
    end

endmodule

// File: rtl/bcd_operand_converter.sv
// Converts a pair of signed packed-BCD operands to two's-complement binary,
// one digit per cycle, with a valid/ready handshake on both sides.
module bcd_operand_converter
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned BIN_W  = BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_a,
    input  logic [4*DIGITS-1:0]   bcd_b,
    input  logic                  neg_a,
    input  logic                  neg_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      num_a,
    output logic [BIN_W-1:0]      num_b,
    output logic                  err_a,
    output logic                  err_b
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = 3;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_operand_converter: DIGITS must be in 1..8");
    end
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $error("bcd_operand_converter: BIN_W too small for DIGITS");
    end

    conv_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     bcd_a_r, bcd_b_r;
    logic             neg_a_r, neg_b_r;
    logic [BIN_W-1:0] acc_a, acc_b;
    logic             err_a_r, err_b_r;

    logic [3:0]       dig_a, dig_b;
    logic [BIN_W-1:0] step_a, step_b;
    logic             derr_a, derr_b;

    assign dig_a = 4'(bcd_a_r >> {cnt, 2'b00});
    assign dig_b = 4'(bcd_b_r >> {cnt, 2'b00});

    bcd_horner_step #(.BIN_W(BIN_W)) u_step_a (
        .acc_in    (acc_a),
        .digit     (dig_a),
        .acc_out   (step_a),
        .digit_err (derr_a)
    );

    bcd_horner_step #(.BIN_W(BIN_W)) u_step_b (
        .acc_in    (acc_b),
        .digit     (dig_b),
        .acc_out   (step_b),
        .digit_err (derr_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bcd_a_r <= '0;
            bcd_b_r <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            acc_a   <= '0;
            acc_b   <= '0;
            err_a_r <= 1'b0;
            err_b_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_a_r <= bcd_a;
                        bcd_b_r <= bcd_b;
                        neg_a_r <= neg_a;
                        neg_b_r <= neg_b;
                        acc_a   <= '0;
                        acc_b   <= '0;
                        err_a_r <= 1'b0;
                        err_b_r <= 1'b0;
                        cnt     <= CNT_W'(DIGITS - 1);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc_a   <= step_a;
                    acc_b   <= step_b;
                    err_a_r <= err_a_r | derr_a;
                    err_b_r <= err_b_r | derr_b;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are only presented in DONE so idle/reset outputs read as zero.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        num_a     = '0;
        num_b     = '0;
        err_a     = 1'b0;
        err_b     = 1'b0;
        if (state == DONE) begin
            err_a = err_a_r;
            err_b = err_b_r;
            if (!err_a_r) begin
                num_a = (neg_a_r && acc_a != '0) ? -acc_a : acc_a;
            end
            if (!err_b_r) begin
                num_b = (neg_b_r && acc_b != '0) ? -acc_b : acc_b;
            end
        end
    end

endmodule
